// File: rtl/mau_pkg.sv
// rtl/mau_pkg.sv - shared opcodes, sequencer state encoding and arith op codes for the MAU
package mau_pkg;

    localparam int MAU_MATRIX_DIM = 8;
    localparam int MAU_NUM_BRAMS  = 4;
    localparam int MAU_OFS_W      = 9;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ARITH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_LOAD       = 2'd1,
        ST_STORE      = 2'd2,
        ST_ARITH_WAIT = 2'd3
    } state_t;

    // Must stay in step with the arithmetic mux select in the compute path.
    typedef enum logic [1:0] {
        AOP_ADD   = 2'd0,
        AOP_SHIFT = 2'd1,
        AOP_SUB   = 2'd2,
        AOP_MUL   = 2'd3
    } arith_op_t;

endpackage

// File: rtl/mau_host_sequencer_if.sv
// rtl/mau_host_sequencer_if.sv - host, BRAM and arithmetic signals of the MAU host sequencer
interface mau_host_sequencer_if #(
    parameter int OFS_W = mau_pkg::MAU_OFS_W
);
    logic [7:0]       host_instruction;
    logic             instr_valid;
    logic [7:0]       data_in;
    logic             data_valid;
    logic [7:0]       data_out;
    logic             data_out_valid;
    logic             busy;
    logic [OFS_W-1:0] offset;
    logic [7:0]       host_input;
    logic [3:0]       line_read_from_host;
    logic [31:0]      bram_to_host;
    logic             arith_start;
    logic [1:0]       arith_op;
    logic [1:0]       arith_dst;
    logic             arith_done;

    modport master (
        input  host_instruction, instr_valid, data_in, data_valid, bram_to_host, arith_done,
        output data_out, data_out_valid, busy, offset, host_input, line_read_from_host,
               arith_start, arith_op, arith_dst
    );

    modport slave (
        output host_instruction, instr_valid, data_in, data_valid, bram_to_host, arith_done,
        input  data_out, data_out_valid, busy, offset, host_input, line_read_from_host,
               arith_start, arith_op, arith_dst
    );
endinterface

// File: rtl/mau_offset_counter.sv
// rtl/mau_offset_counter.sv - clear/enable BRAM offset counter that saturates at its terminal count
module mau_offset_counter #(
    parameter int WIDTH    = 9,
    parameter int TERMINAL = 63
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == WIDTH'(TERMINAL));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mau_host_sequencer.sv
// rtl/mau_host_sequencer.sv - MAU host front end: LOAD/STORE byte streaming and ARITH dispatch.
// Optional LOAD_CHECKSUM_EN adds load_checksum, the XOR of bytes written by the current LOAD.
module mau_host_sequencer
    import mau_pkg::*;
#(
    parameter int MATRIX_DIM = MAU_MATRIX_DIM,
    parameter int OFS_W      = MAU_OFS_W
) (
    input  logic                 clk,
    input  logic                 reset,
    mau_host_sequencer_if.master bus
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [7:0]           load_checksum
`endif
);

    localparam int N = MATRIX_DIM * MATRIX_DIM;

    state_t           state, state_nxt;
    logic [1:0]       opcode;
    logic [1:0]       sel;
    logic             accept;
    logic             load_strobe;
    logic             load_byte;
    logic             store_issue;
    logic             issue_done;
    logic             rd_v;
    logic             rd_last;
    logic             dov_last;
    logic             tc;
    logic [OFS_W-1:0] offset_cnt;
    logic             unused_instr_bits;

    assign opcode            = bus.host_instruction[7:6];
    assign unused_instr_bits = ^bus.host_instruction[1:0];
    assign accept            = (state == ST_IDLE) && bus.instr_valid && (opcode != OP_NOP);
    assign load_strobe       = |bus.line_read_from_host;
    // The strobe cycle of the final byte is still LOAD; a byte arriving then must not be taken.
    assign load_byte         = (state == ST_LOAD) && bus.data_valid && !(load_strobe && tc);
    assign store_issue       = (state == ST_STORE) && !issue_done;
    assign bus.busy          = (state != ST_IDLE);
    assign bus.offset        = offset_cnt;

    // LOAD advances after each strobe so the strobe cycle shows that byte's offset.
    mau_offset_counter #(
        .WIDTH    (OFS_W),
        .TERMINAL (N - 1)
    ) u_offset_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (load_strobe | store_issue),
        .count (offset_cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (opcode)
                        OP_LOAD:  state_nxt = ST_LOAD;
                        OP_STORE: state_nxt = ST_STORE;
                        default:  state_nxt = ST_ARITH_WAIT;
                    endcase
                end
            end
            ST_LOAD:       if (load_strobe && tc) state_nxt = ST_IDLE;
            ST_STORE:      if (bus.data_out_valid && dov_last) state_nxt = ST_IDLE;
            ST_ARITH_WAIT: if (bus.arith_done) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel                     <= '0;
            issue_done              <= 1'b0;
            rd_v                    <= 1'b0;
            rd_last                 <= 1'b0;
            dov_last                <= 1'b0;
            bus.data_out            <= '0;
            bus.data_out_valid      <= 1'b0;
            bus.host_input          <= '0;
            bus.line_read_from_host <= '0;
            bus.arith_start         <= 1'b0;
            bus.arith_op            <= '0;
            bus.arith_dst           <= '0;
        end else begin
            bus.line_read_from_host <= '0;
            bus.arith_start         <= 1'b0;
            // STORE read pipeline: offset cycle -> BRAM data cycle -> data_out cycle.
            rd_v                    <= store_issue;
            rd_last                 <= store_issue && tc;
            bus.data_out_valid      <= rd_v;
            dov_last                <= rd_last;
            if (accept) begin
                sel        <= bus.host_instruction[5:4];
                issue_done <= 1'b0;
                if (opcode == OP_ARITH) begin
                    bus.arith_start <= 1'b1;
                    bus.arith_op    <= bus.host_instruction[3:2];
                    bus.arith_dst   <= bus.host_instruction[5:4];
                end
            end
            if (store_issue && tc) begin
                issue_done <= 1'b1;
            end
            if (load_byte) begin
                bus.host_input          <= bus.data_in;
                bus.line_read_from_host <= 4'(4'b0001 << sel);
            end
            if (rd_v) begin
                bus.data_out <= bus.bram_to_host[8*sel +: 8];
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_checksum <= '0;
        end else if (accept && (opcode == OP_LOAD)) begin
            load_checksum <= '0;
        end else if (load_byte) begin
            load_checksum <= load_checksum ^ bus.data_in;
        end
    end
`endif

endmodule

// File: tb/tb_mau_host_sequencer.sv
// tb/tb_mau_host_sequencer.sv - directed self-checking bench for mau_host_sequencer
module tb_mau_host_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   dov_count;

    always #5 clk = ~clk;

    mau_host_sequencer_if #(.OFS_W(9)) bus();

`ifdef LOAD_CHECKSUM_EN
    logic [7:0] load_checksum;
`endif

    mau_host_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef LOAD_CHECKSUM_EN
        ,
        .load_checksum (load_checksum)
`endif
    );

    // Registered BRAM read model; lane b2 returns the offset itself, other lanes are distinct.
    always @(posedge clk) begin
        bus.bram_to_host <= {bus.offset[7:0] ^ 8'hC0, bus.offset[7:0],
                             bus.offset[7:0] ^ 8'h40, bus.offset[7:0] ^ 8'h80};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_instr(input logic [7:0] instr);
        bus.instr_valid      = 1'b1;
        bus.host_instruction = instr;
        tick();
        bus.instr_valid      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.data_valid = 1'b1;
        bus.data_in    = b;
        tick();
        bus.data_valid = 1'b0;
    endtask

    initial begin
        bus.host_instruction = 8'h00;
        bus.instr_valid      = 1'b0;
        bus.data_in          = 8'h00;
        bus.data_valid       = 1'b0;
        bus.arith_done       = 1'b0;
        repeat (3) tick();

        check("rst_busy",   32'(bus.busy), 0);
        check("rst_offset", 32'(bus.offset), 0);
        check("rst_strobe", 32'(bus.line_read_from_host), 0);
        check("rst_outs",   32'({bus.data_out_valid, bus.data_out, bus.host_input,
                                 bus.arith_start, bus.arith_op, bus.arith_dst}), 0);
        reset = 1'b1;
        tick();

        // Reset in the middle of a LOAD
        send_instr(8'h50);
        check("t1_busy", 32'(bus.busy), 1);
        for (int k = 0; k < 10; k++) begin
            send_byte(8'(k + 16));
            check("t1_wr", 32'({bus.line_read_from_host, bus.offset}), 32'({4'b0010, 9'(k)}));
        end
        reset = 1'b0;
        #1;
        check("t1_abort", 32'({bus.busy, bus.offset, bus.line_read_from_host, bus.host_input}), 0);
        tick();
        reset = 1'b1;
        tick();
        check("t1_idle", 32'(bus.busy), 0);

        // Full LOAD into b1 with gaps; accept-cycle byte dropped, mid-LOAD STORE instr ignored
        bus.data_valid = 1'b1;
        bus.data_in    = 8'hEE;
        send_instr(8'h50);
        bus.data_valid = 1'b0;
        check("t2_drop", 32'({bus.busy, bus.line_read_from_host}), 32'({1'b1, 4'b0000}));
        check("t2_ofs0", 32'(bus.offset), 0);
        for (int k = 0; k < 64; k++) begin
            if (k % 5 == 2) tick();
            if (k == 20) begin
                bus.instr_valid      = 1'b1;
                bus.host_instruction = 8'h90;
            end
            send_byte(8'(k));
            bus.instr_valid = 1'b0;
            check("t2_wr", 32'({bus.line_read_from_host, bus.offset, bus.host_input, bus.busy}),
                  32'({4'b0010, 9'(k), 8'(k), 1'b1}));
        end
        send_byte(8'h77);
        check("t2_post", 32'({bus.line_read_from_host, bus.busy, bus.offset}),
              32'({4'b0000, 1'b0, 9'd63}));

        // STORE from b2 with data_valid held high throughout
        send_instr(8'hA0);
        bus.data_valid = 1'b1;
        bus.data_in    = 8'h55;
        dov_count      = 0;
        for (int j = 0; j < 68; j++) begin
            logic [8:0] e_ofs;
            logic       e_dov;
            logic [7:0] e_do;
            logic       e_busy;
            e_ofs  = (j < 63) ? 9'(j) : 9'd63;
            e_dov  = (j >= 2) && (j <= 65);
            e_do   = e_dov ? 8'(j - 2) : 8'h00;
            e_busy = (j <= 65);
            if (bus.data_out_valid) dov_count++;
            check("t3_store",
                  32'({bus.offset, bus.data_out_valid, bus.data_out_valid ? bus.data_out : 8'h00,
                       bus.busy, bus.line_read_from_host}),
                  32'({e_ofs, e_dov, e_do, e_busy, 4'b0000}));
            tick();
        end
        bus.data_valid = 1'b0;
        check("t3_count", 32'(dov_count), 64);

        // ARITH mul into b1, LOAD instr during the wait is ignored
        send_instr(8'hDC);
        check("t4_start", 32'({bus.arith_start, bus.arith_op, bus.arith_dst, bus.busy}),
              32'({1'b1, 2'd3, 2'd1, 1'b1}));
        for (int j = 1; j < 20; j++) begin
            if (j == 5) send_instr(8'h50);
            else tick();
            check("t4_wait", 32'({bus.arith_start, bus.arith_op, bus.arith_dst, bus.busy,
                                  bus.line_read_from_host}),
                  32'({1'b0, 2'd3, 2'd1, 1'b1, 4'b0000}));
        end
        bus.arith_done = 1'b1;
        tick();
        bus.arith_done = 1'b0;
        check("t4_done", 32'(bus.busy), 0);
        tick();
        check("t4_idle", 32'({bus.busy, bus.arith_start}), 0);

`ifdef LOAD_CHECKSUM_EN
        send_instr(8'h40);
        send_byte(8'h01);
        send_byte(8'h02);
        repeat (62) send_byte(8'h00);
        tick();
        check("t6_sum", 32'({bus.busy, load_checksum}), 32'({1'b0, 8'h03}));
        send_instr(8'h40);
        check("t6_clr", 32'(load_checksum), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
